// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM encoding and line-address helper for the cache miss/refill path.
package mem_ctrl_pkg;

    localparam int DEF_TAG_W  = 20;
    localparam int DEF_IDX_W  = 8;
    localparam int DEF_LINE_W = 128;
    localparam int OFFSET_W   = 4;
    localparam int LADDR_W    = DEF_TAG_W + DEF_IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        FILL = 2'd3
    } state_e;

    function automatic logic [LADDR_W-1:0] line_addr(input logic [31:0] addr);
        return addr[31:OFFSET_W];
    endfunction

endpackage

// File: rtl/miss_rr_arb.sv
// Two-requester round-robin arbiter. The pointer picks the winner on a tie and
// moves to the other port once the served transaction completes.
module miss_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       served_id_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_id_o = (req_i == 2'b11) ? ptr_q : req_i[1];
        grant_o    = (|req_i) ? (grant_id_o ? 2'b10 : 2'b01) : 2'b00;
        ptr_d      = advance_i ? ~served_id_i : ptr_q;
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/miss_refill_ctrl.sv
// Miss refill sequencer: arbitrates the two pipes' line misses, writes back a dirty
// victim, reads the refill line and returns it to the cache in a one-cycle fill pulse.
module miss_refill_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TAG_W  = DEF_TAG_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   miss0,
    input  logic                   miss1,
    input  logic [31:0]            addr0,
    input  logic [31:0]            addr1,
    input  logic                   dirty0,
    input  logic                   dirty1,
    input  logic [TAG_W-1:0]       vtag0,
    input  logic [TAG_W-1:0]       vtag1,
    input  logic [LINE_W-1:0]      vdata0,
    input  logic [LINE_W-1:0]      vdata1,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [TAG_W+IDX_W-1:0] mem_addr,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    input  logic [LINE_W-1:0]      mem_rdata,
    output logic                   fill_valid,
    output logic                   fill0,
    output logic                   fill1,
    output logic [TAG_W+IDX_W-1:0] fill_line,
    output logic [LINE_W-1:0]      fill_data,
    output logic                   stall0,
    output logic                   stall1
);

    localparam int LA_W = TAG_W + IDX_W;

    state_e            state_q, state_d;
    logic              gid_q;
    logic [LA_W-1:0]   line_q;
    logic [TAG_W-1:0]  vtag_q;
    logic [LINE_W-1:0] vdata_q;
    logic [LINE_W-1:0] rdata_q;

    logic [1:0]        grant;
    logic              grant_id;
    logic              grant_en;
    logic              rd_done;
    logic              advance;
    logic              sel_dirty;
    logic [LA_W-1:0]   sel_line;

    miss_rr_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       ({miss1, miss0}),
        .advance_i   (advance),
        .served_id_i (gid_q),
        .grant_o     (grant),
        .grant_id_o  (grant_id)
    );

    assign sel_dirty = grant_id ? dirty1 : dirty0;
    assign sel_line  = grant_id ? line_addr(addr1) : line_addr(addr0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_d    = state_q;
        grant_en   = 1'b0;
        rd_done    = 1'b0;
        advance    = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        fill_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    grant_en = 1'b1;
                    state_d  = sel_dirty ? WB : RD;
                end
            end
            WB: begin
                mem_we   = 1'b1;
                mem_addr = {vtag_q, line_q[IDX_W-1:0]};
                if (mem_ack) state_d = RD;
            end
            RD: begin
                mem_re   = 1'b1;
                mem_addr = line_q;
                if (mem_ack) begin
                    rd_done = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                fill_valid = 1'b1;
                advance    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the line buffers are ordinary registers, not a RAM, so they take the reset too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gid_q   <= 1'b0;
            line_q  <= '0;
            vtag_q  <= '0;
            vdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (grant_en) begin
                gid_q   <= grant_id;
                line_q  <= sel_line;
                vtag_q  <= grant_id ? vtag1 : vtag0;
                vdata_q <= grant_id ? vdata1 : vdata0;
            end
            if (rd_done) rdata_q <= mem_rdata;
        end
    end

    // The granted port always fills; the other rides along if it misses on the same line.
    always_comb begin
        fill0 = 1'b0;
        fill1 = 1'b0;
        if (fill_valid) begin
            fill0 = ~gid_q | (miss0 & (line_addr(addr0) == line_q));
            fill1 = gid_q | (miss1 & (line_addr(addr1) == line_q));
        end
    end

    assign mem_wdata = mem_we ? vdata_q : '0;
    assign fill_line = fill_valid ? line_q : '0;
    assign fill_data = fill_valid ? rdata_q : '0;
    assign stall0    = miss0 & ~fill0;
    assign stall1    = miss1 & ~fill1;

endmodule

// File: tb/tb_miss_refill_ctrl.sv
// Self-checking bench for miss_refill_ctrl: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_miss_refill_ctrl;

    localparam int TW = 20;
    localparam int LW = 128;
    localparam int AW = 28;
    localparam int OP_WB   = 1;
    localparam int OP_RD   = 2;
    localparam int OP_FILL = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          miss0, miss1;
    logic [31:0]   addr0, addr1;
    logic          dirty0, dirty1;
    logic [TW-1:0] vtag0, vtag1;
    logic [LW-1:0] vdata0, vdata1;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_ack;
    logic [LW-1:0] mem_rdata;
    logic          fill_valid, fill0, fill1;
    logic [AW-1:0] fill_line;
    logic [LW-1:0] fill_data;
    logic          stall0, stall1;

    int   checks = 0;
    int   errors = 0;
    int   ack_delay = 0;
    logic ack_force = 1'b0;
    int   wait_cnt = 0;
    logic cmp_en = 1'b0;

    miss_refill_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .miss0      (miss0),
        .miss1      (miss1),
        .addr0      (addr0),
        .addr1      (addr1),
        .dirty0     (dirty0),
        .dirty1     (dirty1),
        .vtag0      (vtag0),
        .vtag1      (vtag1),
        .vdata0     (vdata0),
        .vdata1     (vdata1),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fill_valid (fill_valid),
        .fill0      (fill0),
        .fill1      (fill1),
        .fill_line  (fill_line),
        .fill_data  (fill_data),
        .stall0     (stall0),
        .stall1     (stall1)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the line address.
    function automatic logic [LW-1:0] mem_image(input logic [AW-1:0] la);
        return {4'h5, la, 4'hA, ~la, 4'h3, la ^ 28'h5A5A5A5, 4'hC, la + 28'd1};
    endfunction

    // Memory responder: acks a request after ack_delay wait cycles.
    assign mem_rdata = mem_image(mem_addr);
    assign mem_ack   = ack_force | ((mem_re | mem_we) & (wait_cnt >= ack_delay));

    always @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= 0;
        else if ((mem_re | mem_we) && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model: a granted miss becomes a list of pending operations.
    int            m_ops[$];
    int            m_ptr = 0;
    int            m_gid = 0;
    logic [AW-1:0] m_line = '0;
    logic [TW-1:0] m_vtag = '0;
    logic [LW-1:0] m_vdata = '0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_ops.delete();
                m_ptr = 0;
            end else if (m_ops.size() == 0) begin
                if (miss0 || miss1) begin
                    m_gid   = (miss0 && miss1) ? m_ptr : (miss1 ? 1 : 0);
                    m_line  = (m_gid == 1) ? addr1[31:4] : addr0[31:4];
                    m_vtag  = (m_gid == 1) ? vtag1 : vtag0;
                    m_vdata = (m_gid == 1) ? vdata1 : vdata0;
                    if ((m_gid == 1) ? dirty1 : dirty0) m_ops.push_back(OP_WB);
                    m_ops.push_back(OP_RD);
                    m_ops.push_back(OP_FILL);
                end
            end else if (m_ops[0] == OP_FILL) begin
                void'(m_ops.pop_front());
                m_ptr = 1 - m_gid;
            end else if (mem_ack) begin
                void'(m_ops.pop_front());
            end
        end
    end

    task automatic compare_cycle();
        int   head;
        logic ef0, ef1;
        head = (m_ops.size() != 0) ? m_ops[0] : 0;
        ef0  = (head == OP_FILL) && (m_gid == 0 || (miss0 && addr0[31:4] == m_line));
        ef1  = (head == OP_FILL) && (m_gid == 1 || (miss1 && addr1[31:4] == m_line));
        check("mem_we", mem_we, head == OP_WB);
        check("mem_re", mem_re, head == OP_RD);
        check("fill_valid", fill_valid, head == OP_FILL);
        check("fill0", fill0, ef0);
        check("fill1", fill1, ef1);
        check("stall0", stall0, miss0 & ~ef0);
        check("stall1", stall1, miss1 & ~ef1);
        if (head == OP_WB) begin
            check("wb_addr", mem_addr, {m_vtag, m_line[7:0]});
            check("wb_data", mem_wdata, m_vdata);
        end
        if (head == OP_RD) check("rd_addr", mem_addr, m_line);
        if (head == OP_FILL) begin
            check("fill_line", fill_line, m_line);
            check("fill_data", fill_data, mem_image(m_line));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) compare_cycle();
        end
    end

    // Observation of one transaction, starting in the cycle its miss is first visible.
    int            we_n, re_n, fill_k;
    logic [1:0]    fbits;
    logic [AW-1:0] first_we_addr, first_re_addr;

    task automatic observe(input int budget, input string nm);
        we_n = 0;
        re_n = 0;
        fill_k = -1;
        fbits = 2'b00;
        first_we_addr = '0;
        first_re_addr = '0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (mem_we) begin
                if (we_n == 0) first_we_addr = mem_addr;
                we_n++;
            end
            if (mem_re) begin
                if (re_n == 0) first_re_addr = mem_addr;
                re_n++;
            end
            if (fill_valid) begin
                fill_k = k;
                fbits  = {fill1, fill0};
                break;
            end
        end
        check({nm, " fill seen"}, fill_k >= 0, 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        miss0 = 1'b0;  miss1 = 1'b0;
        addr0 = '0;    addr1 = '0;
        dirty0 = 1'b0; dirty1 = 1'b0;
        vtag0 = '0;    vtag1 = '0;
        vdata0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        vdata1 = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset outputs", {mem_re, mem_we, fill_valid, stall0, stall1}, 5'b0);
        step();

        // 1: clean miss on port 0, ack in the request cycle
        addr0 = 32'h0000_1230; miss0 = 1'b1;
        @(negedge clk);
        check("t1 k0 no read", mem_re, 1'b0);
        @(negedge clk);
        check("t1 k1 read", mem_re, 1'b1);
        check("t1 k1 addr", mem_addr, 28'h0000123);
        @(negedge clk);
        check("t1 k2 fill", {fill_valid, fill1, fill0}, 3'b101);
        check("t1 k2 data", fill_data, mem_image(28'h0000123));
        step();
        miss0 = 1'b0;
        @(negedge clk);
        check("t1 k3 stall0", stall0, 1'b0);
        step();

        // 2: dirty miss on port 1, every request acked after 2 wait cycles
        addr1 = 32'h0004_5670; vtag1 = 20'hABCDE; dirty1 = 1'b1;
        ack_delay = 2; miss1 = 1'b1;
        observe(30, "t2");
        check("t2 we cycles", we_n, 3);
        check("t2 we addr", first_we_addr, 28'hABCDE67);
        check("t2 re cycles", re_n, 3);
        check("t2 re addr", first_re_addr, 28'h0004567);
        check("t2 fill cycle", fill_k, 7);
        check("t2 fill bits", fbits, 2'b10);
        step();
        miss1 = 1'b0; dirty1 = 1'b0; ack_delay = 0;

        // 3: both ports on different lines; the pointer alternates the winner
        addr0 = 32'h0000_2000; addr1 = 32'h0000_3000;
        miss0 = 1'b1; miss1 = 1'b1;
        observe(10, "t3a");
        check("t3a fill bits", fbits, 2'b01);
        check("t3a fill cycle", fill_k, 2);
        step();
        addr0 = 32'h0000_4000;
        observe(10, "t3b");
        check("t3b fill bits", fbits, 2'b10);
        check("t3b fill cycle", fill_k, 2);
        step();
        miss1 = 1'b0;
        observe(10, "t3c");
        check("t3c fill bits", fbits, 2'b01);
        check("t3c re addr", first_re_addr, 28'h0000400);
        step();
        miss0 = 1'b0;

        // 4: both ports on the same line are merged into one read
        addr0 = 32'h0000_0100; addr1 = 32'h0000_010C;
        miss0 = 1'b1; miss1 = 1'b1;
        observe(10, "t4");
        check("t4 fill bits", fbits, 2'b11);
        check("t4 re cycles", re_n, 1);
        check("t4 we cycles", we_n, 0);
        step();
        miss0 = 1'b0; miss1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4 no second access", {mem_re, mem_we}, 2'b00);
        end
        step();

        // 5: reset in the middle of a writeback, then restart
        addr0 = 32'h0000_5550; vtag0 = 20'h12345; dirty0 = 1'b1;
        ack_delay = 5; miss0 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5 wb started", seen, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t5 we drops", {mem_we, mem_re}, 2'b00);
        repeat (2) begin
            @(negedge clk);
            check("t5 no fill in reset", fill_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        observe(20, "t5 restart");
        check("t5 fill bits", fbits, 2'b01);
        check("t5 we cycles", we_n, 6);
        check("t5 we addr", first_we_addr, 28'h1234555);
        check("t5 fill cycle", fill_k, 13);
        step();
        miss0 = 1'b0; dirty0 = 1'b0; ack_delay = 0;

        // 6: stray ack while idle changes nothing
        ack_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6 idle quiet", {mem_re, mem_we, fill_valid}, 3'b000);
        end
        step();
        ack_force = 1'b0;
        addr0 = 32'h0000_6660; miss0 = 1'b1;
        observe(10, "t6");
        check("t6 fill cycle", fill_k, 2);
        check("t6 fill bits", fbits, 2'b01);
        check("t6 re addr", first_re_addr, 28'h0000666);
        step();
        miss0 = 1'b0;

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miss_refill_ctrl.md
Name: miss_refill_ctrl

Overview:
- Sequences main-memory traffic for the dual-ported write-back data cache.
- Accepts line-miss requests from the two issue pipes and arbitrates between them round-robin.
- For each granted miss: writes back a dirty victim line, reads the refill line, and returns it to the cache in a one-cycle fill pulse.
- Sits between the cache and the 128-bit main memory. Drives the per-pipe stall signals.

Parameters:
TAG_W, 20, tag width, addr[31:12]
IDX_W, 8, set index width, addr[11:4]
LINE_W, 128, line width in bits (16-byte line, offset addr[3:0])

Ports:
clk  in  1  clock; everything is sampled on the rising edge
reset  in  1  asynchronous, active-high reset
miss0, miss1  in  1  per-port line-miss request; held high until that port's fill
addr0, addr1  in  32  miss address; stable while miss is high
dirty0, dirty1  in  1  victim line of the addressed set is dirty
vtag0, vtag1  in  TAG_W  victim line tag
vdata0, vdata1  in  LINE_W  victim line data
mem_re  out  1  memory line read request
mem_we  out  1  memory line write request
mem_addr  out  TAG_W+IDX_W  memory line address
mem_wdata  out  LINE_W  writeback data
mem_ack  in  1  memory completes the current re/we; may assert in the same cycle as the request
mem_rdata  in  LINE_W  read data, valid when mem_ack is high during a read
fill_valid  out  1  one-cycle refill pulse
fill0, fill1  out  1  which port(s) the refill satisfies
fill_line  out  TAG_W+IDX_W  refilled line address
fill_data  out  LINE_W  refilled line data
stall0, stall1  out  1  pipe stall: stallN = missN & ~fillN (combinational)

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; round-robin pointer goes to port 0.
  - All registered outputs clear to 0; mem_re and mem_we drop at once.
  - An in-flight transaction is abandoned; no fill is produced for it.
- FSM states: IDLE, WB, RD, FILL.
- IDLE:
  - Only one port missing: grant that port.
  - Both ports missing: grant the port named by the pointer.
  - On a grant, latch the line address addr[31:4], dirty, vtag, vdata and the grant id.
  - Next state is WB if dirty, else RD. No miss: stay in IDLE.
- WB:
  - mem_we=1, mem_addr={vtag_latched, idx_latched}, mem_wdata=vdata_latched.
  - Outputs are held until mem_ack; on ack go to RD.
- RD:
  - mem_re=1, mem_addr=latched line address, held until mem_ack.
  - On ack, capture mem_rdata and go to FILL.
- FILL (exactly one cycle):
  - fill_valid=1, fill_line=latched line, fill_data=captured data.
  - fill bit set for the granted port.
  - Merge: the other port's fill bit is also set if that port's miss is high and its addr[31:4] equals the latched line.
  - Pointer moves to the non-granted port. Next state is IDLE.
- mem_re and mem_we are never high together. mem_ack is ignored in IDLE and FILL.
- Latency, with mem_ack asserted in the same cycle as the request:
  - Clean miss: fill pulse in the 3rd cycle after miss is first sampled (IDLE, RD, FILL).
  - Dirty miss: 4th cycle (IDLE, WB, RD, FILL).
  - Each cycle mem_ack is held low adds one cycle.
- Back-to-back: FILL always returns to IDLE, so the next grant is made in the cycle after FILL.
- Worst case: a port waits for at most one full transaction of the other port.
- Same set, different line, for the second port: serviced after the first fill. The cache has updated the victim by then, so dirty1/vtag1 are re-sampled at grant, not when the miss was first raised.
- Miss dropped while its transaction is pending (protocol violation): the transaction still completes and the fill pulses. The pointer still advances.

Decomposition:
- Shared package mem_ctrl_pkg:
  - state encoding (IDLE=0, WB=1, RD=2, FILL=3)
  - TAG_W, IDX_W, LINE_W defaults
  - line-address width and the line-address extraction helper
- One sub-module, miss_rr_arb: 2-requester round-robin arbiter.
  - Inputs: req[1:0], advance, reset.
  - Outputs: grant one-hot and grant id.

Test Plan:
1. Reset, then miss0 clean at addr 0x0000_1230, mem_ack tied 1 -> mem_re in cycle 1 with mem_addr=0x00001_23; fill_valid, fill0 in cycle 2; stall0 low from cycle 3.
2. miss1 dirty, vtag1=0xABCDE, addr1=0x0004_5670, ack delayed 2 cycles per request -> mem_we with mem_addr=0xABCDE_67 and vdata1 for 3 cycles, then mem_re with mem_addr=0x00045_67 for 3 cycles, then fill1.
3. miss0 and miss1 both raised from reset, different lines -> port 0 filled first, port 1 next; raising both again then serves port 1 first, since the pointer alternates.
4. miss0 addr 0x100, miss1 addr 0x10C (same line) -> single RD; fill_valid with fill0=fill1=1; no second memory access.
5. Assert reset in the middle of WB -> mem_we drops asynchronously, no fill; after release with miss0 held high, the transaction restarts from IDLE with port 0 granted.
6. mem_ack pulsed while in IDLE -> no state change, no outputs.
